// File: rtl/vs_tdm_pkg.sv
// Shared definitions for the TDM serializer/deserializer pair.
// The framing state type and the lane-index width helper live here.
package vs_tdm_pkg;

  typedef enum logic [0:0] {
    TDM_HUNT = 1'b0,
    TDM_RUN  = 1'b1
  } tdm_state_e;

  // Width of a lane index; at least one bit so the counter always has storage
  function automatic int unsigned lane_idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vs_mod_counter.sv
// Enable-driven modulo-Mod counter with a synchronous load that takes priority.
// Counts 0..Mod-1 and wraps to 0.
module vs_mod_counter #(
  parameter int unsigned Mod = 4,
  parameter int unsigned W   = (Mod > 1) ? $clog2(Mod) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == W'(Mod - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vs_tdm_demux.sv
// Round-robin TDM deserializer: aligns on start-of-frame, fills a shadow bank one
// word per lane and publishes each complete frame on registered parallel outputs.
module vs_tdm_demux
  import vs_tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [WIDTH-1:0]       in_data,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  output logic                   sync_err,
  output logic                   locked
);

  localparam int unsigned IdxW = lane_idx_width(LANES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  tdm_state_e       state_q, state_d;
  logic [WIDTH-1:0] shadow_q [LANES];
  logic [WIDTH-1:0] shadow_d [LANES];
  logic [WIDTH-1:0] bank_q   [LANES];
  logic             out_valid_q;
  logic             sync_err_q, sync_err_d;
  logic             frame_done;
  logic             cnt_en, cnt_load;
  logic [IdxW-1:0]  lane_idx;

  vs_mod_counter #(
    .Mod (LANES),
    .W   (IdxW)
  ) u_lane_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .en_i       (cnt_en),
    .load_i     (cnt_load),
    .load_val_i (IdxW'(1)),
    .cnt_o      (lane_idx)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    sync_err_d = 1'b0;
    frame_done = 1'b0;
    cnt_en     = 1'b0;
    cnt_load   = 1'b0;
    unique case (state_q)
      TDM_HUNT: begin
        if (in_valid && in_sof) begin
          shadow_d[0] = in_data;
          cnt_load    = 1'b1;
          state_d     = TDM_RUN;
        end
      end
      TDM_RUN: begin
        if (in_valid) begin
          if (in_sof) begin
            // An SOF anywhere but lane 0 aborts the partial frame and restarts it
            shadow_d[0] = in_data;
            cnt_load    = 1'b1;
            sync_err_d  = (lane_idx != '0);
          end else if (lane_idx == '0) begin
            sync_err_d = 1'b1;
            state_d    = TDM_HUNT;
          end else begin
            shadow_d[lane_idx] = in_data;
            cnt_en             = 1'b1;
            frame_done         = (lane_idx == LastIdx);
          end
        end
      end
      default: state_d = TDM_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TDM_HUNT;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int k = 0; k < int'(LANES); k++) begin
        shadow_q[k] <= '0;
        bank_q[k]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= frame_done;
      sync_err_q  <= sync_err_d;
      shadow_q    <= shadow_d;
      if (frame_done) begin
        bank_q <= shadow_d;
      end
    end
  end

  for (genvar k = 0; k < int'(LANES); k++) begin : g_pack
    assign out_data[k*WIDTH +: WIDTH] = bank_q[k];
  end

  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == TDM_RUN);

endmodule

// File: tb/tb_vs_tdm_demux.sv
// Directed bench for vs_tdm_demux (WIDTH=4, LANES=4) with hand-computed frames.
module tb_vs_tdm_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_sof;
  logic [3:0]  in_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        sync_err;
  logic        locked;

  int checks = 0;
  int errors = 0;
  int vpulses = 0;
  int epulses = 0;

  vs_tdm_demux #(
    .WIDTH (4),
    .LANES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sync_err  (sync_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of input, then sample 1 ns after the edge
  task automatic send(input logic v, input logic s, input logic [3:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    if (out_valid) vpulses++;
    if (sync_err)  epulses++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    @(posedge clk); @(posedge clk);
    #1;
    reset = 1'b0;
    vpulses = 0;
    epulses = 0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    do_reset();
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_err", 32'(sync_err), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);

    // Basic frame
    send(1, 1, 4'd2);
    check("basic_locked", 32'(locked), 32'h1);
    send(1, 0, 4'd4);
    send(1, 0, 4'd6);
    check("basic_novalid", 32'(out_valid), 32'h0);
    send(1, 0, 4'd8);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_data", 32'(out_data), 32'h8642);
    send(0, 0, 4'd0);
    check("basic_vdrop", 32'(out_valid), 32'h0);
    check("basic_vcount", 32'(vpulses), 32'd1);
    check("basic_ecount", 32'(epulses), 32'd0);

    // Gaps between words: distinct values so a premature update shows
    vpulses = 0;
    send(1, 1, 4'd1);
    for (int i = 0; i < 3; i++) send(0, 0, 4'hF);
    send(1, 0, 4'd3);
    for (int i = 0; i < 3; i++) send(0, 1, 4'hF);
    send(1, 0, 4'd5);
    for (int i = 0; i < 3; i++) send(0, 0, 4'hF);
    check("gap_hold", 32'(out_data), 32'h8642);
    send(1, 0, 4'd7);
    check("gap_data", 32'(out_data), 32'h7531);
    send(0, 0, 4'd0);
    check("gap_vcount", 32'(vpulses), 32'd1);
    check("gap_ecount", 32'(epulses), 32'd0);

    // Hunt from reset
    do_reset();
    send(1, 0, 4'd5);
    send(1, 0, 4'd7);
    check("hunt_unlocked", 32'(locked), 32'h0);
    send(1, 1, 4'd1);
    check("hunt_locked", 32'(locked), 32'h1);
    send(1, 0, 4'd3);
    send(1, 0, 4'd5);
    send(1, 0, 4'd7);
    check("hunt_data", 32'(out_data), 32'h7531);
    check("hunt_vcount", 32'(vpulses), 32'd1);
    check("hunt_ecount", 32'(epulses), 32'd0);

    // Early SOF
    epulses = 0;
    send(1, 1, 4'd2);
    send(1, 0, 4'd4);
    send(1, 1, 4'd9);
    check("esof_err", 32'(sync_err), 32'h1);
    check("esof_hold", 32'(out_data), 32'h7531);
    check("esof_locked", 32'(locked), 32'h1);
    send(1, 0, 4'd10);
    check("esof_errdrop", 32'(sync_err), 32'h0);
    send(1, 0, 4'd11);
    send(1, 0, 4'd12);
    check("esof_valid", 32'(out_valid), 32'h1);
    check("esof_data", 32'(out_data), 32'hCBA9);
    check("esof_ecount", 32'(epulses), 32'd1);

    // Missing SOF after a complete frame
    send(1, 1, 4'd2);
    send(1, 0, 4'd4);
    send(1, 0, 4'd6);
    send(1, 0, 4'd8);
    check("msof_frame", 32'(out_data), 32'h8642);
    send(1, 0, 4'd3);
    check("msof_err", 32'(sync_err), 32'h1);
    check("msof_locked", 32'(locked), 32'h0);
    check("msof_hold", 32'(out_data), 32'h8642);
    send(0, 0, 4'd0);
    check("msof_errdrop", 32'(sync_err), 32'h0);

    // Reset mid-frame, with a competing SOF word during reset
    send(1, 1, 4'd2);
    send(1, 0, 4'd4);
    reset = 1'b1;
    send(1, 1, 4'd7);
    reset = 1'b0;
    check("mrst_data", 32'(out_data), 32'h0);
    check("mrst_locked", 32'(locked), 32'h0);
    check("mrst_valid", 32'(out_valid), 32'h0);
    vpulses = 0;
    send(1, 1, 4'd1);
    send(1, 0, 4'd2);
    send(1, 0, 4'd3);
    check("mrst_partial", 32'(out_data), 32'h0);
    send(1, 0, 4'd4);
    check("mrst_valid2", 32'(out_valid), 32'h1);
    check("mrst_data2", 32'(out_data), 32'h4321);
    send(0, 0, 4'd0);
    check("mrst_vcount", 32'(vpulses), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
